// File: rtl/dtcore32_lsu.sv
// dtcore32 MEM-stage load/store unit: drives a req/gnt/rvalid data bus,
// builds byte lanes for stores, aligns/extends load data and raises
// misaligned / access-fault traps.
module dtcore32_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        MEM_req_valid_i,
  input  logic        MEM_wr_en_i,
  input  logic [2:0]  MEM_funct3_i,
  input  logic [31:0] MEM_addr_i,
  input  logic [31:0] MEM_wdata_i,
  input  logic        MEM_flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_err_i,
  output logic        MEM_stall_o,
  output logic        MEM_done_o,
  output logic [31:0] MEM_rdata_o,
  output logic        MEM_trap_valid_o,
  output logic [3:0]  MEM_trap_cause_o,
  output logic [31:0] MEM_trap_addr_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DONE, S_ERR} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          kill_q, kill_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;   // full byte address; [1:0] is the lane offset
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          misaligned;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [31:0]   rd_shift;
  logic [31:0]   rd_ext;
  logic          timeout;

  // Access size decode for the incoming op: funct3[1:0] 00=byte, 01=half, else word
  always_comb begin
    misaligned = 1'b0;
    be_new     = 4'b1111;
    wdata_new  = MEM_wdata_i;
    case (MEM_funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << MEM_addr_i[1:0];
        wdata_new = {4{MEM_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = MEM_addr_i[0];
        be_new     = 4'b0011 << MEM_addr_i[1:0];
        wdata_new  = {2{MEM_wdata_i[15:0]}};
      end
      default: misaligned = (MEM_addr_i[1:0] != 2'b00);
    endcase
  end

  // Load alignment: move the addressed byte/half down to bit 0, then extend
  always_comb begin
    rd_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Gnt/rvalid take priority over timeout when they arrive in the last allowed cycle
  assign timeout = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

  // Next-state, datapath captures and all handshake/trap outputs
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    kill_d           = kill_q;
    err_d            = err_q;
    we_d             = we_q;
    be_d             = be_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    f3_d             = f3_q;
    rdata_d          = rdata_q;
    dmem_req_o       = 1'b0;
    MEM_stall_o      = 1'b0;
    MEM_done_o       = 1'b0;
    MEM_trap_valid_o = 1'b0;
    MEM_trap_cause_o = 4'd0;
    MEM_trap_addr_o  = 32'd0;
    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (MEM_req_valid_i && !MEM_flush_i) begin
          if (misaligned) begin
            MEM_trap_valid_o = 1'b1;
            MEM_trap_cause_o = MEM_wr_en_i ? 4'd6 : 4'd4;
            MEM_trap_addr_o  = MEM_addr_i;
          end else begin
            MEM_stall_o = 1'b1;
            we_d        = MEM_wr_en_i;
            be_d        = be_new;
            addr_d      = MEM_addr_i;
            wdata_d     = wdata_new;
            f3_d        = MEM_funct3_i;
            err_d       = 1'b0;
            cnt_d       = '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        dmem_req_o  = 1'b1;
        MEM_stall_o = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        kill_d      = kill_q | MEM_flush_i;
        if (dmem_gnt_i)   state_d = S_RESP;
        else if (timeout) state_d = S_ERR;
      end
      S_RESP: begin
        MEM_stall_o = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        kill_d      = kill_q | MEM_flush_i;
        if (dmem_rvalid_i) begin
          rdata_d = rd_ext;
          err_d   = dmem_err_i;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        MEM_done_o       = !err_q && !kill_q;
        MEM_trap_valid_o = err_q && !kill_q;
        MEM_trap_cause_o = MEM_trap_valid_o ? (we_q ? 4'd7 : 4'd5) : 4'd0;
        MEM_trap_addr_o  = MEM_trap_valid_o ? addr_q : 32'd0;
        state_d          = S_IDLE;
      end
      S_ERR: begin
        MEM_trap_valid_o = !kill_q;
        MEM_trap_cause_o = MEM_trap_valid_o ? (we_q ? 4'd7 : 4'd5) : 4'd0;
        MEM_trap_addr_o  = MEM_trap_valid_o ? addr_q : 32'd0;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dmem_we_o    = we_q;
  assign dmem_be_o    = be_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_wdata_o = wdata_q;
  assign MEM_rdata_o  = rdata_q;

  // State and captured-transaction registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dtcore32_lsu.sv
// Bench for dtcore32_lsu: directed cases plus randomized ops against a
// byte-level reference model of lane selection and load extension.
module tb_dtcore32_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, wr_en, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] baddr, bwdata;
  logic        gnt, rvalid, berr;
  logic [31:0] brdata;
  logic        stall, done, trap;
  logic [31:0] rdata_o;
  logic [3:0]  cause;
  logic [31:0] taddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dtcore32_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .MEM_req_valid_i(valid), .MEM_wr_en_i(wr_en), .MEM_funct3_i(funct3),
    .MEM_addr_i(addr), .MEM_wdata_i(wdata), .MEM_flush_i(flush),
    .dmem_req_o(req), .dmem_we_o(we), .dmem_be_o(be), .dmem_addr_o(baddr),
    .dmem_wdata_o(bwdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(brdata), .dmem_err_i(berr),
    .MEM_stall_o(stall), .MEM_done_o(done), .MEM_rdata_o(rdata_o),
    .MEM_trap_valid_o(trap), .MEM_trap_cause_o(cause), .MEM_trap_addr_o(taddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: sizes in bytes, lanes derived byte by byte ----
  function automatic int sz(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    logic [31:0] v, x;
    int n;
    n = sz(f3);
    v = rd >> (8 * off);
    if (n == 4) return v;
    x = v & ((32'd1 << (8 * n)) - 32'd1);
    if (!f3[2] && x >= (32'd1 << (8 * n - 1))) x = x - (32'd1 << (8 * n));
    return x;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input int off);
    logic [3:0] b;
    b = 4'd0;
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + sz(f3));
    return b;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] o;
    o = 32'd0;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % sz(f3)) +: 8];
    return o;
  endfunction

  // One aligned op; caller is just after a clock edge with the DUT in IDLE.
  // gd = cycles of req before gnt, rdl = RESP cycles before rvalid, kill_at = flush cycle (-1 none)
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic e,
                        input int gd, input int rdl, input int kill_at);
    int last;
    logic killed;
    last   = 3 + gd + rdl;
    killed = 1'b0;
    valid = 1'b1; wr_en = w; funct3 = f3; addr = a; wdata = wd; flush = 1'b0;
    #1;
    chk("acc_stall", 32'(stall), 32'd1);
    chk("acc_req",   32'(req),   32'd0);
    chk("acc_trap",  32'(trap),  32'd0);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      gnt    = (c == 1 + gd);
      rvalid = (c == 2 + gd + rdl);
      brdata = rvalid ? rd : $urandom;
      berr   = rvalid ? e : 1'($urandom_range(0, 1));
      flush  = (c == kill_at);
      if (c == kill_at) killed = 1'b1;
      #1;
      chk("req",   32'(req),   32'(c <= 1 + gd));
      chk("stall", 32'(stall), 32'(c < last));
      chk("done",  32'(done),  32'(c == last && !e && !killed));
      chk("trap",  32'(trap),  32'(c == last && e && !killed));
      if (c == 1) begin
        chk("bus_addr", baddr, {a[31:2], 2'b00});
        chk("bus_we",   32'(we), 32'(w));
        chk("bus_be",   32'(be), 32'(ref_be(f3, int'(a[1:0]))));
        if (w) chk("bus_wdata", bwdata, ref_wdata(f3, wd));
      end
      if (c == last && e && !killed) begin
        chk("fault_cause", 32'(cause), w ? 32'd7 : 32'd5);
        chk("fault_addr",  taddr, a);
      end
      if (c == last && !w && !e && !killed)
        chk("load_data", rdata_o, ref_load(f3, int'(a[1:0]), rd));
    end
    @(posedge clk); #1;
    valid = 1'b0; gnt = 1'b0; rvalid = 1'b0; flush = 1'b0;
    #1;
    chk("post_done",  32'(done),  32'd0);
    chk("post_req",   32'(req),   32'd0);
    chk("post_stall", 32'(stall), 32'd0);
  endtask

  task automatic mis(input logic w, input logic [2:0] f3, input logic [31:0] a);
    valid = 1'b1; wr_en = w; funct3 = f3; addr = a; flush = 1'b0;
    #1;
    chk("mis_trap",  32'(trap),  32'd1);
    chk("mis_cause", 32'(cause), w ? 32'd6 : 32'd4);
    chk("mis_addr",  taddr, a);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_req",   32'(req),   32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    #1;
    chk("mis_req_after", 32'(req), 32'd0);
  endtask

  logic [2:0] f3tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    rst_n = 1'b0; valid = 1'b0; wr_en = 1'b0; flush = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; gnt = 1'b0; rvalid = 1'b0; brdata = 32'd0; berr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   32'(req),   32'd0);
    chk("rst_we",    32'(we),    32'd0);
    chk("rst_be",    32'(be),    32'd0);
    chk("rst_addr",  baddr,      32'd0);
    chk("rst_wdata", bwdata,     32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_rdata", rdata_o,    32'd0);
    chk("rst_trap",  32'(trap),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lw, minimum latency
    run_op(1'b0, 3'b010, 32'h1000, 32'd0, 32'hDEADBEEF, 1'b0, 0, 0, -1);
    chk("lw_const", rdata_o, 32'hDEADBEEF);
    // lb / lbu sign handling on top byte
    run_op(1'b0, 3'b000, 32'h1003, 32'd0, 32'h80123456, 1'b0, 0, 0, -1);
    chk("lb_const", rdata_o, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h1003, 32'd0, 32'h80123456, 1'b0, 1, 1, -1);
    chk("lbu_const", rdata_o, 32'h00000080);
    // sh upper half
    run_op(1'b1, 3'b001, 32'h1002, 32'h0000BEEF, 32'd0, 1'b0, 2, 0, -1);
    chk("sh_be",    32'(be), 32'h0000000C);
    chk("sh_wdata", bwdata,  32'hBEEFBEEF);
    chk("sh_we",    32'(we), 32'd1);
    // misaligned lw and sh
    mis(1'b0, 3'b010, 32'h1001);
    mis(1'b1, 3'b001, 32'h2003);

    // sw with gnt never given: timeout after 8 REQ cycles
    valid = 1'b1; wr_en = 1'b1; funct3 = 3'b010; addr = 32'h2000; wdata = 32'h12345678;
    #1;
    chk("to_acc_stall", 32'(stall), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1; #1;
      chk("to_req",   32'(req),   32'd1);
      chk("to_stall", 32'(stall), 32'd1);
      chk("to_trap",  32'(trap),  32'd0);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    #1;
    chk("to_fault",       32'(trap),  32'd1);
    chk("to_fault_cause", 32'(cause), 32'd7);
    chk("to_fault_addr",  taddr,      32'h2000);
    chk("to_req_drop",    32'(req),   32'd0);
    chk("to_stall_drop",  32'(stall), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b1; berr = 1'b1;
    #1;
    chk("stray_req",  32'(req),  32'd0);
    chk("stray_trap", 32'(trap), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0; berr = 1'b0;
    #1;
    chk("stray_done",  32'(done),  32'd0);
    chk("stray_trap2", 32'(trap),  32'd0);
    chk("stray_stall", 32'(stall), 32'd0);

    // flush in RESP, then rvalid with error: silent completion
    run_op(1'b0, 3'b010, 32'h3000, 32'd0, 32'h55AA55AA, 1'b1, 1, 2, 3);

    // flush in IDLE blocks acceptance
    valid = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = 32'h4000; flush = 1'b1;
    #1;
    chk("fl_idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    #1;
    chk("fl_idle_req", 32'(req), 32'd0);

    // reset while in REQ
    valid = 1'b1; wr_en = 1'b0; funct3 = 3'b010; addr = 32'h5000;
    @(posedge clk); #1;
    #1;
    chk("rr_req", 32'(req), 32'd1);
    rst_n = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    #1;
    chk("rr_req_drop", 32'(req),   32'd0);
    chk("rr_stall",    32'(stall), 32'd0);
    chk("rr_done",     32'(done),  32'd0);
    chk("rr_trap",     32'(trap),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized ops
    for (int k = 0; k < 40; k++) begin
      logic        w, e;
      logic [2:0]  f3;
      logic [31:0] a;
      int          n, gd, rdl, ka;
      w  = 1'($urandom_range(0, 1));
      f3 = w ? f3tab[$urandom_range(0, 2)] : f3tab[$urandom_range(0, 4)];
      n  = sz(f3);
      a  = $urandom & ~(32'(n) - 32'd1);
      if (n > 1 && $urandom_range(0, 5) == 0) begin
        mis(w, f3, a | 32'd1);
      end else begin
        e   = ($urandom_range(0, 7) == 0);
        gd  = $urandom_range(0, 3);
        rdl = $urandom_range(0, 3);
        ka  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2 + gd + rdl) : -1;
        run_op(w, f3, a, $urandom, $urandom, e, gd, rdl, ka);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
